// File: rtl/bexkat_intunit.sv
// ---------------------------------------------------------------------------
// bexkat_intunit
//
// Iterative integer multiply/divide unit for the bexkat core. One request is
// accepted at a time through a start/busy/done handshake. Multiplies produce
// a double-width product. Divides and mods produce a quotient/remainder pair.
// Signed and unsigned forms are both supported.
//
// Parameters:
//   WIDTH  operand width in bits (even, >= 4)
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   start  request; accepted only while busy is low
//   func   0 MULU, 1 MULS, 2 DIVU, 3 DIVS, 4 MODU, 5 MODS, 6/7 reserved
//   in1    multiplicand / dividend
//   in2    multiplier / divisor
//   busy   operation in progress
//   done   one-cycle completion pulse
//   out    result, held until the next completion
//            for multiplies: full 2*WIDTH product
//            for divides: {remainder, quotient}
//            for remainder ops: {quotient, remainder}
//   div0   last completed operation divided by zero; held with out
// ---------------------------------------------------------------------------
module bexkat_intunit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         func,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out,
  output logic               div0
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    RUN,
    FIX
  } state_t;

  state_t             state;
  logic [2:0]         func_q;
  logic [WIDTH-1:0]   op1;
  logic [WIDTH-1:0]   op2;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic [CW-1:0]      cnt;
  logic               neg_main;
  logic               neg_rem;
  logic               zero_div;

  // Operation decode from the latched function code
  logic is_mul;
  logic is_mod;
  logic is_rsvd;
  logic is_signed;

  assign is_mul    = (func_q[2:1] == 2'b00);
  assign is_mod    = (func_q[2:1] == 2'b10);
  assign is_rsvd   = (func_q[2:1] == 2'b11);
  assign is_signed = func_q[0] & ~is_rsvd;

  // Operand magnitudes. The most negative value maps onto itself, and that
  // is the correct unsigned magnitude 2^(WIDTH-1).
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;

  assign mag1 = (is_signed && op1[WIDTH-1]) ? -op1 : op1;
  assign mag2 = (is_signed && op2[WIDTH-1]) ? -op2 : op2;

  // Multiply step: the multiplier in op2 is consumed MSB first. The
  // accumulator doubles each cycle and adds the multiplicand when the bit
  // is set.
  logic [2*WIDTH-1:0] acc_next;

  assign acc_next = {acc[2*WIDTH-2:0], 1'b0} +
                    (op2[WIDTH-1] ? {{WIDTH{1'b0}}, op1} : '0);

  // Restoring divide step: op1 shifts the dividend out of its MSB and the
  // quotient into its LSB. The trial is one bit wider than the remainder
  // register, so its top bit of the difference is a clean borrow flag.
  logic [WIDTH+1:0] trial;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  assign trial  = {rem, op1[WIDTH-1]};
  assign diff   = trial - {2'b00, op2};
  assign borrow = diff[WIDTH+1];

  // Final result formation, consumed only in FIX. On a zero divisor, op1
  // still holds the raw dividend because PREP leaves it untouched.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rmd;
  logic [2*WIDTH-1:0] result;

  always_comb begin
    prod = neg_main ? -acc : acc;
    quo  = neg_main ? -op1 : op1;
    rmd  = neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    if (zero_div) begin
      quo = '1;
      rmd = op1;
    end
    if (is_rsvd) begin
      result = '0;
    end else if (is_mul) begin
      result = prod;
    end else if (is_mod) begin
      result = {quo, rmd};
    end else begin
      result = {rmd, quo};
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      func_q   <= '0;
      op1      <= '0;
      op2      <= '0;
      acc      <= '0;
      rem      <= '0;
      cnt      <= '0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      zero_div <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      out      <= '0;
      div0     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            func_q <= func;
            op1    <= in1;
            op2    <= in2;
            busy   <= 1'b1;
            state  <= PREP;
          end
        end

        PREP: begin
          // The quotient takes the product's sign rule. The remainder
          // follows the dividend.
          neg_main <= is_signed & (op1[WIDTH-1] ^ op2[WIDTH-1]);
          neg_rem  <= is_signed & op1[WIDTH-1];
          acc      <= '0;
          rem      <= '0;
          cnt      <= CW'(WIDTH);
          zero_div <= 1'b0;
          if (is_rsvd) begin
            state <= FIX;
          end else if (!is_mul && op2 == '0) begin
            zero_div <= 1'b1;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            state    <= FIX;
          end else begin
            op1   <= mag1;
            op2   <= mag2;
            state <= RUN;
          end
        end

        RUN: begin
          if (is_mul) begin
            acc <= acc_next;
            op2 <= {op2[WIDTH-2:0], 1'b0};
          end else begin
            rem <= borrow ? trial[WIDTH:0] : diff[WIDTH:0];
            op1 <= {op1[WIDTH-2:0], ~borrow};
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= FIX;
          end
        end

        FIX: begin
          out   <= result;
          div0  <= zero_div;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
